// File: rtl/counter_mod_sv_if.sv
// rtl/counter_mod_sv_if.sv - control/status bundle of the modulo counter
interface counter_mod_sv_if #(
   parameter int WIDTH = 8
);
   logic             clr;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             en;
   logic             up_dn;
   logic             sat_mode;
   logic             flag_clr;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             ovf;
   logic             udf;

   modport master (
      output clr, load, load_val, en, up_dn, sat_mode, flag_clr,
      input  count, tc, ovf, udf
   );

   modport slave (
      input  clr, load, load_val, en, up_dn, sat_mode, flag_clr,
      output count, tc, ovf, udf
   );
endinterface

// File: rtl/counter_mod_sv.sv
// rtl/counter_mod_sv.sv - up/down modulo counter with prescaler, wrap/saturate and sticky flags
module counter_mod_sv #(
   parameter int WIDTH    = 8,
   parameter int MAX_VAL  = 2**WIDTH-1,
   parameter int PRESCALE = 1
) (
   input logic             clk,
   input logic             rst_n,
   counter_mod_sv_if.slave bus
);
   localparam int               PSC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE-1);
   localparam logic [WIDTH-1:0] MAX_C    = WIDTH'(MAX_VAL);

   logic [WIDTH-1:0] count_q, count_nxt;
   logic [PSC_W-1:0] psc_q, psc_nxt;
   logic             tc_q, tc_nxt;
   logic             ovf_q, udf_q;
   logic             ovf_set, udf_set;

   always_comb begin
      count_nxt = count_q;
      psc_nxt   = psc_q;
      tc_nxt    = 1'b0;
      ovf_set   = 1'b0;
      udf_set   = 1'b0;
      if (bus.clr) begin
         count_nxt = '0;
         psc_nxt   = '0;
      end else if (bus.load) begin
         count_nxt = (bus.load_val > MAX_C) ? MAX_C : bus.load_val;
         psc_nxt   = '0;
      end else if (bus.en) begin
         if (psc_q == PSC_LAST) begin
            psc_nxt = '0;
            // Boundary step: wrap to the opposite end or hold, always flagged
            if (bus.up_dn) begin
               if (count_q == MAX_C) begin
                  tc_nxt    = 1'b1;
                  ovf_set   = 1'b1;
                  count_nxt = bus.sat_mode ? count_q : '0;
               end else begin
                  count_nxt = count_q + 1'b1;
               end
            end else begin
               if (count_q == '0) begin
                  tc_nxt    = 1'b1;
                  udf_set   = 1'b1;
                  count_nxt = bus.sat_mode ? count_q : MAX_C;
               end else begin
                  count_nxt = count_q - 1'b1;
               end
            end
         end else begin
            psc_nxt = psc_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         psc_q   <= '0;
         tc_q    <= 1'b0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         count_q <= count_nxt;
         psc_q   <= psc_nxt;
         tc_q    <= tc_nxt;
         // Set dominates a simultaneous flag_clr
         ovf_q   <= ovf_set | (ovf_q & ~bus.flag_clr);
         udf_q   <= udf_set | (udf_q & ~bus.flag_clr);
      end
   end

   assign bus.count = count_q;
   assign bus.tc    = tc_q;
   assign bus.ovf   = ovf_q;
   assign bus.udf   = udf_q;
endmodule
